// File: rtl/ika9958_vram_slot_arb.sv
// ika9958_vram_slot_arb: VRAM access-slot scheduler driven by the RCC clock enables.
// Latency: grant, slot_start and ack are registered on the boundary edge (phase wraps SLOT_LEN-1 -> 0).
// Backpressure: level requests are held by the requester until its ack pulse; no queueing here.
//
// Ports:
//   i_phiA            master clock, all flops on posedge
//   i_RST_async_n     asynchronous active-low reset
//   i_phiA_NCEN       21.48 MHz clock enable, nothing changes while low
//   i_phiL_PCEN       phiL positive-edge enable (slot tick when qualified by i_phiA_NCEN)
//   i_disp_en/_req    display active period / display fetch needed
//   i_cpu_req         CPU access request level,     o_cpu_ack  one-enabled-cycle grant pulse
//   i_cmd_req         command engine request level, o_cmd_ack  one-enabled-cycle grant pulse
//   o_grant           slot owner: 0 idle, 1 disp, 2 cpu, 3 cmd, 4 refresh
//   o_slot_start      first cycle of a slot, o_slot_phase tick index in slot, o_busy grant != idle
//
// Optional feature macro: IKA9958_VRAM_REFRESH_EN
//   Defined: a 4-bit slot counter forces every 16th slot to refresh (code 4), overriding disp.
//   Undefined: no slot counter, code 4 never produced.

module ika9958_vram_slot_arb #(
   parameter int SLOT_LEN       = 4,
   parameter int CPU_STARVE_MAX = 3
) (
   input  logic       i_phiA,
   input  logic       i_RST_async_n,
   input  logic       i_phiA_NCEN,
   input  logic       i_phiL_PCEN,
   input  logic       i_disp_en,
   input  logic       i_disp_req,
   input  logic       i_cpu_req,
   output logic       o_cpu_ack,
   input  logic       i_cmd_req,
   output logic       o_cmd_ack,
   output logic [2:0] o_grant,
   output logic       o_slot_start,
   output logic [2:0] o_slot_phase,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DISP    = 3'd1,
      ST_CPU     = 3'd2,
      ST_CMD     = 3'd3,
      ST_REFRESH = 3'd4
   } grant_t;

   localparam logic [2:0] PHASE_LAST = 3'(SLOT_LEN - 1);
   localparam logic [2:0] STARVE_MAX = 3'(CPU_STARVE_MAX);

   grant_t     state_q, state_d;
   logic [2:0] phase_q, phase_d;
   logic [2:0] starve_q, starve_d;
   logic       slot_start_q, slot_start_d;
   logic       cpu_ack_q, cpu_ack_d;
   logic       cmd_ack_q, cmd_ack_d;

   logic       tick;
   logic       boundary;
   logic       refresh_due;

   assign tick     = i_phiA_NCEN & i_phiL_PCEN;
   assign boundary = tick && (phase_q == PHASE_LAST);

`ifdef IKA9958_VRAM_REFRESH_EN
   logic [3:0] slot_cnt_q, slot_cnt_d;

   // The counter holds the number of boundaries seen (mod 16); when it reads 15
   // the slot being opened is the 16th and goes to refresh.
   assign refresh_due = (slot_cnt_q == 4'd15);

   always_comb begin
      slot_cnt_d = slot_cnt_q;
      if (boundary) begin
         slot_cnt_d = slot_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge i_phiA or negedge i_RST_async_n) begin
      if (!i_RST_async_n) begin
         slot_cnt_q <= 4'd0;
      end else if (i_phiA_NCEN) begin
         slot_cnt_q <= slot_cnt_d;
      end
   end
`else
   assign refresh_due = 1'b0;
`endif

   // Next-state / next-output logic. Everything is evaluated against the request
   // levels present on the boundary edge itself, so a request dropped on that edge
   // loses the slot.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      starve_d     = starve_q;
      slot_start_d = 1'b0;
      cpu_ack_d    = 1'b0;
      cmd_ack_d    = 1'b0;

      if (tick) begin
         phase_d = boundary ? 3'd0 : phase_q + 3'd1;
      end

      if (boundary) begin
         slot_start_d = 1'b1;

         if (refresh_due) begin
            state_d = ST_REFRESH;
         end else if (i_disp_en && i_disp_req) begin
            state_d = ST_DISP;
         end else if (i_cmd_req && (starve_q == STARVE_MAX)) begin
            // CPU has held the bus long enough while cmd waited.
            state_d   = ST_CMD;
            cmd_ack_d = 1'b1;
         end else if (i_cpu_req) begin
            state_d   = ST_CPU;
            cpu_ack_d = 1'b1;
         end else if (i_cmd_req) begin
            state_d   = ST_CMD;
            cmd_ack_d = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end

         // Starve counter only tracks CPU wins that cost a waiting cmd a slot.
         if (!i_cmd_req || (state_d == ST_CMD)) begin
            starve_d = 3'd0;
         end else if ((state_d == ST_CPU) && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
         end
      end
   end

   // Single enable gate: pulses clear on the next enabled edge and hold while
   // i_phiA_NCEN is low, because their next value is only captured when enabled.
   always_ff @(posedge i_phiA or negedge i_RST_async_n) begin
      if (!i_RST_async_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= 3'd0;
         starve_q     <= 3'd0;
         slot_start_q <= 1'b0;
         cpu_ack_q    <= 1'b0;
         cmd_ack_q    <= 1'b0;
      end else if (i_phiA_NCEN) begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         starve_q     <= starve_d;
         slot_start_q <= slot_start_d;
         cpu_ack_q    <= cpu_ack_d;
         cmd_ack_q    <= cmd_ack_d;
      end
   end

   assign o_grant      = state_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_slot_start = slot_start_q;
   assign o_slot_phase = phase_q;
   assign o_cpu_ack    = cpu_ack_q;
   assign o_cmd_ack    = cmd_ack_q;

endmodule

// File: tb/tb_ika9958_vram_slot_arb.sv
// tb_ika9958_vram_slot_arb: directed stimulus with a scoreboard queue of expected slot outcomes.
// Latency: monitor samples 1 ns after every posedge; boundaries predicted by its own phase model.
// Backpressure: none; bench drives request levels and holds them across slots as a requester would.

module tb_ika9958_vram_slot_arb;

   localparam int SLOT_LEN       = 4;
   localparam int CPU_STARVE_MAX = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ncen = 1'b0;
   logic       pcen = 1'b0;
   logic       disp_en = 1'b0;
   logic       disp_req = 1'b0;
   logic       cpu_req = 1'b0;
   logic       cmd_req = 1'b0;
   logic       cpu_ack, cmd_ack, slot_start, busy;
   logic [2:0] grant, slot_phase;

   always #5 clk = ~clk;

   ika9958_vram_slot_arb #(
      .SLOT_LEN       (SLOT_LEN),
      .CPU_STARVE_MAX (CPU_STARVE_MAX)
   ) dut (
      .i_phiA        (clk),
      .i_RST_async_n (rst_n),
      .i_phiA_NCEN   (ncen),
      .i_phiL_PCEN   (pcen),
      .i_disp_en     (disp_en),
      .i_disp_req    (disp_req),
      .i_cpu_req     (cpu_req),
      .o_cpu_ack     (cpu_ack),
      .i_cmd_req     (cmd_req),
      .o_cmd_ack     (cmd_ack),
      .o_grant       (grant),
      .o_slot_start  (slot_start),
      .o_slot_phase  (slot_phase),
      .o_busy        (busy)
   );

   // Scoreboard entry: {grant[2:0], cpu_ack, cmd_ack}
   logic [4:0] sb[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic [2:0] m_phase = 3'd0;
   logic [2:0] m_grant = 3'd0;
   logic       m_en, m_pc, m_bnd;
   logic [4:0] m_e;
   logic       p_start = 1'b0, p_cack = 1'b0, p_mack = 1'b0;
   logic [2:0] p_grant = 3'd0, p_phase = 3'd0;

   initial begin
      forever begin
         @(posedge clk);
         m_en = ncen;
         m_pc = pcen;
         #1;
         if (!rst_n) begin
            m_phase = 3'd0;
            m_grant = 3'd0;
            chk("rst_hold_grant", grant, 0);
            chk("rst_hold_start", slot_start, 0);
         end else if (!m_en) begin
            chk("hold_start", slot_start, p_start);
            chk("hold_cpu_ack", cpu_ack, p_cack);
            chk("hold_cmd_ack", cmd_ack, p_mack);
            chk("hold_grant", grant, p_grant);
            chk("hold_phase", slot_phase, p_phase);
         end else begin
            m_bnd = m_pc && (m_phase == 3'(SLOT_LEN - 1));
            if (m_pc) m_phase = m_bnd ? 3'd0 : m_phase + 3'd1;
            chk("phase", slot_phase, m_phase);
            if (m_bnd) begin
               chk("slot_start_on_boundary", slot_start, 1);
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_empty: boundary at %0t with no expected entry", $time);
               end else begin
                  m_e     = sb.pop_front();
                  m_grant = m_e[4:2];
                  chk("boundary_cpu_ack", cpu_ack, m_e[1]);
                  chk("boundary_cmd_ack", cmd_ack, m_e[0]);
               end
            end else begin
               chk("slot_start_idle", slot_start, 0);
               chk("cpu_ack_idle", cpu_ack, 0);
               chk("cmd_ack_idle", cmd_ack, 0);
            end
            chk("grant", grant, m_grant);
            chk("busy", busy, (m_grant != 3'd0));
         end
         p_start = slot_start;
         p_cack  = cpu_ack;
         p_mack  = cmd_ack;
         p_grant = grant;
         p_phase = slot_phase;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic n, input logic p);
      ncen = n;
      pcen = p;
      @(negedge clk);
   endtask

   // One phiL tick: PCEN high on every 4th enabled cycle.
   task automatic tick();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
   endtask

   // A full slot, then two NCEN-low cycles (PCEN high) that must not move anything.
   task automatic slot();
      for (int i = 0; i < SLOT_LEN; i++) tick();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
   endtask

   task automatic expect_slot(input logic [2:0] g, input logic ca, input logic ma);
      sb.push_back({g, ca, ma});
   endtask

   task automatic run_slot(input logic [2:0] g, input logic ca, input logic ma);
      expect_slot(g, ca, ma);
      slot();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with enables active: nothing may count.
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("reset_grant", grant, 0);
      chk("reset_start", slot_start, 0);
      chk("reset_phase", slot_phase, 0);
      chk("reset_busy", busy, 0);
      chk("reset_acks", {cpu_ack, cmd_ack}, 0);
      step(1'b1, 1'b0);
      rst_n = 1'b1;

      // 1: idle slots, first boundary after SLOT_LEN ticks
      run_slot(3'd0, 1'b0, 1'b0);
      run_slot(3'd0, 1'b0, 1'b0);

      // 2: cpu and cmd both held -> cpu x3, cmd, repeating
      cpu_req = 1'b1;
      cmd_req = 1'b1;
      for (int r = 0; r < 2; r++) begin
         run_slot(3'd2, 1'b1, 1'b0);
         run_slot(3'd2, 1'b1, 1'b0);
         run_slot(3'd2, 1'b1, 1'b0);
         run_slot(3'd3, 1'b0, 1'b1);
      end
      cmd_req = 1'b0;

      // 3: disp wins over cpu while disp_en, then cpu gets the slot
      disp_en  = 1'b1;
      disp_req = 1'b1;
      run_slot(3'd1, 1'b0, 1'b0);
      run_slot(3'd1, 1'b0, 1'b0);
      run_slot(3'd1, 1'b0, 1'b0);
      disp_en = 1'b0;
      run_slot(3'd2, 1'b1, 1'b0);
      disp_req = 1'b0;

      // 4: cpu_req dropped exactly on the boundary edge -> idle
      expect_slot(3'd0, 1'b0, 1'b0);
      for (int i = 0; i < SLOT_LEN - 1; i++) tick();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      cpu_req = 1'b0;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      run_slot(3'd0, 1'b0, 1'b0);

      // cmd alone, then starve counter cleared by a boundary without cmd_req
      cmd_req = 1'b1;
      run_slot(3'd3, 1'b0, 1'b1);
      cpu_req = 1'b1;
      run_slot(3'd2, 1'b1, 1'b0);
      run_slot(3'd2, 1'b1, 1'b0);
      cmd_req = 1'b0;
      run_slot(3'd2, 1'b1, 1'b0);
      cmd_req = 1'b1;
      run_slot(3'd2, 1'b1, 1'b0);
      run_slot(3'd2, 1'b1, 1'b0);
      run_slot(3'd2, 1'b1, 1'b0);
      run_slot(3'd3, 1'b0, 1'b1);
      cmd_req = 1'b0;

      // 5: async reset at phase 2 of a CPU slot
      run_slot(3'd2, 1'b1, 1'b0);
      tick();
      tick();
      ncen = 1'b1;
      pcen = 1'b0;
      @(posedge clk);
      #3;
      chk("pre_rst_grant", grant, 2);
      chk("pre_rst_phase", slot_phase, 2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_grant", grant, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_phase", slot_phase, 0);
      chk("async_rst_acks", {cpu_ack, cmd_ack}, 0);
      chk("async_rst_start", slot_start, 0);
      @(negedge clk);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      rst_n = 1'b1;
      run_slot(3'd2, 1'b1, 1'b0);
      cpu_req = 1'b0;

      // 6: disp held across 17 slots from a fresh reset (slot 16 refresh when enabled)
      rst_n = 1'b0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      rst_n    = 1'b1;
      disp_en  = 1'b1;
      disp_req = 1'b1;
      for (int k = 1; k <= 17; k++) begin
`ifdef IKA9958_VRAM_REFRESH_EN
         if (k == 16) run_slot(3'd4, 1'b0, 1'b0);
         else         run_slot(3'd1, 1'b0, 1'b0);
`else
         run_slot(3'd1, 1'b0, 1'b0);
`endif
      end
      disp_en  = 1'b0;
      disp_req = 1'b0;

      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ika9958_vram_slot_arb.md
Name: ika9958_vram_slot_arb

Overview:
- VRAM access-slot scheduler driven by the RCC clock enables.
- Splits phiL time into fixed-length slots and grants each slot to one of three requesters:
  - display fetch,
  - CPU port,
  - command engine.
- Sits between the RCC domain (phiA / phiA_NCEN / phiL_PCEN) and the VRAM interface sequencer, which consumes o_grant and o_slot_phase.

Parameters:
SLOT_LEN, 4, phiL ticks per slot; legal range 2..8.
CPU_STARVE_MAX, 3, consecutive CPU grants while cmd is waiting before cmd is forced; legal range 1..7.

Ports:
i_phiA  in  1  master clock; all flops on posedge.
i_RST_async_n  in  1  asynchronous active-low reset.
i_phiA_NCEN  in  1  21.48 MHz clock enable; flops update only when high.
i_phiL_PCEN  in  1  phiL positive-edge enable; slot tick.
i_disp_en  in  1  display active period.
i_disp_req  in  1  display fetch needed.
i_cpu_req  in  1  CPU access request (level).
o_cpu_ack  out  1  CPU slot granted pulse.
i_cmd_req  in  1  command engine request (level).
o_cmd_ack  out  1  command slot granted pulse.
o_grant  out  3  current slot owner: 0 idle, 1 disp, 2 cpu, 3 cmd, 4 refresh.
o_slot_start  out  1  first-cycle-of-slot pulse.
o_slot_phase  out  3  tick index within slot, 0..SLOT_LEN-1.
o_busy  out  1  o_grant != 0.

Behaviour:
- Clock and reset (already decided): single clock i_phiA; i_RST_async_n asynchronous, active-low.
- Reset values: all outputs 0; internal phase, starve counter and slot counter 0.
- Clock enable: tick = i_phiA_NCEN & i_phiL_PCEN. No state changes when i_phiA_NCEN is low.
- Phase counter:
  - Increments on tick.
  - At phase == SLOT_LEN-1 with tick, it wraps to 0; this is the boundary.
  - First boundary occurs SLOT_LEN ticks after reset release.
- Arbitration:
  - Evaluated only at a boundary, using request levels sampled on that same edge.
  - A request dropped on the boundary edge is not granted.
- Priority, highest first:
  1. refresh (optional feature);
  2. disp, if i_disp_en & i_disp_req;
  3. cmd, if i_cmd_req & starve == CPU_STARVE_MAX;
  4. cpu;
  5. cmd;
  6. idle.
- Grant state machine:
  - States IDLE/DISP/CPU/CMD/REFRESH map 1:1 onto o_grant.
  - The only transitions are at boundaries. Any state may go to any state. o_grant is held for the whole slot.
- Registered outputs at the boundary edge:
  - o_grant takes the winner's code.
  - o_slot_start = 1.
  - The winner's ack = 1, for cpu or cmd only.
  - All three are visible after that edge.
- Pulse width: o_slot_start and the acks clear at the next phiA_NCEN-qualified edge, giving exactly one enabled cycle. They hold while i_phiA_NCEN is low.
- Request handshake:
  - A requester keeps req high until ack.
  - If req is still high at the next boundary, it competes again; there is no implicit de-duplication.
- Starve counter (3 bits):
  - Increments, saturating at CPU_STARVE_MAX, on a CPU grant while i_cmd_req = 1.
  - Clears on a cmd grant, or at any boundary where i_cmd_req = 0.
  - Holds on disp, idle and refresh grants.
- o_slot_phase = phase counter; it is 0 in the cycle where o_slot_start = 1.
- Reset mid-slot: immediate clear of all outputs, with no completion of the current slot.
- Glitch rule: the ack is never asserted without o_grant changing to that requester in the same cycle.

Optional Feature:
Macro IKA9958_VRAM_REFRESH_EN.
- Defined:
  - A 4-bit slot counter increments at every boundary and wraps at 15.
  - The boundary where the counter is 15 before incrementing gives the next slot to refresh (o_grant = 4), overriding disp.
  - The starve counter holds during refresh.
- Undefined:
  - No slot counter is instantiated.
  - Code 4 is never produced.

Test Plan:
1. Reset release, SLOT_LEN = 4, no requests, phiL_PCEN every 4th enabled cycle -> o_slot_start first pulses after 4 ticks; o_grant = 0; o_busy = 0; o_slot_phase cycles 0,1,2,3.
2. cpu_req and cmd_req both held high, CPU_STARVE_MAX = 3 -> grant sequence cpu, cpu, cpu, cmd, cpu, cpu, cpu, cmd; each ack is a single enabled cycle aligned with o_slot_start.
3. disp_en = 1, disp_req = 1, cpu_req = 1 -> o_grant = 1 every slot, o_cpu_ack never asserts. Drop disp_en -> next boundary gives o_grant = 2 with o_cpu_ack = 1.
4. cpu_req deasserted exactly on the boundary edge -> that slot is idle (o_grant = 0) and no ack pulses.
5. Assert i_RST_async_n = 0 at phase 2 of a CPU slot, without a clock edge -> o_grant, acks and o_busy go to 0 immediately. After release, the first boundary comes 4 ticks later.
6. With IKA9958_VRAM_REFRESH_EN and disp_req held high -> o_grant = 4 on slots 16, 32, 48 and 1 otherwise. Without the macro -> o_grant = 1 on every slot.
